ennemy_wave: RTL and testbench
==============================

// Module: ennemy_wave
// PURPOSE
//  Parametrised multi-slot enemy generator for the shooter playfield.
//  Manages N_ENEMY independent falling enemies: pseudo-random X spawn, timed spawning,
//  per-slot collision kill and avoided detection. Feeds the renderer (X/Y buses) and
//  the score/lives logic (avoided/killed pulses). Advances only on the frame-rate clk_en tick.
// PARAMETERS
//  N_ENEMY      4    number of enemy slots (1..8)
//  X_MIN        72   leftmost spawn X
//  X_RANGE      128  spawn X span; X = X_MIN + (lfsr[7:0] % X_RANGE)
//  Y_MAX        238  Y at/after which an enemy is avoided
//  OFFSCREEN_X  400  X of an inactive slot (outside the visible area)
//  SPAWN_PERIOD 60   clk_en ticks between spawn attempts (>=1)
//  PLAY_SCENE   2'd1 scene code in which enemies run
// PORTS
//  clk        in   1          system clock
//  rst        in   1          synchronous active-high reset
//  clk_en     in   1          movement tick, one clk wide
//  scene      in   2          current game scene
//  colision   in   N_ENEMY    per-slot hit from the collision checker
//  X          out  9*N_ENEMY  packed X, slot i at [9i+8:9i]
//  Y          out  9*N_ENEMY  packed Y, slot i at [9i+8:9i]
//  active     out  N_ENEMY    slot i is alive and drawn
//  avoided    out  N_ENEMY    1-clk pulse: slot i reached Y_MAX
//  killed     out  N_ENEMY    1-clk pulse: slot i hit while active
// BEHAVIOUR
//  - Reset: active=0, X=OFFSCREEN_X, Y=0, avoided=killed=0, spawn_cnt=0, lfsr=8'hA5, step=1.
//  - Outputs are registered; all effects appear the clk after the cause.
//  - Per-slot states: IDLE (active=0) and FALL (active=1).
//  - Per-slot priority each clk: rst > scene!=PLAY_SCENE > Y>=Y_MAX > colision > clk_en move.
//  - scene!=PLAY_SCENE: every slot to IDLE, X=OFFSCREEN_X, Y=0, spawn_cnt=0, no pulses.
//  - FALL, Y>=Y_MAX: to IDLE, X=OFFSCREEN_X, Y=0, avoided[i]=1 for one clk.
//  - FALL, colision[i]: to IDLE, X=OFFSCREEN_X, Y=0, killed[i]=1 for one clk.
//    Collision has priority over a clk_en move in the same clk.
//  - IDLE: colision[i] ignored, no pulse.
//  - FALL, clk_en: Y <= Y+step, 9-bit add. Y_MAX+step must be <= 511 (no wrap).
//  - lfsr: 8-bit Fibonacci, taps 8,6,5,4, advances every clk (including outside play).
//  - spawn_cnt counts clk_en ticks in play. Reaching SPAWN_PERIOD-1 resets it and attempts a spawn.
//  - Spawn target: lowest-index slot with registered active=0. A slot freed this clk is not
//    eligible until the next clk. If no slot is free, the spawn is dropped and the counter still wraps.
//  - Spawned slot: FALL, Y=0, X=X_MIN+(lfsr % X_RANGE). Only one spawn per clk_en tick.
//  - Mid-operation rst: same clk behaviour as power-on reset; pending pulses are cleared.
// CONFIGURATION
//  ENNEMY_DIFFICULTY_EN defined:
//   - 5-bit avoided counter; each group of 8 avoided enemies raises step by 1, capped at 4.
//   - Counter and step are cleared by rst and on leaving PLAY_SCENE.
//   - With several avoided pulses in one clk, the counter adds the popcount.
//  ENNEMY_DIFFICULTY_EN undefined: step is constant 1, no counter logic is generated.
// TESTING
//  1 rst=1 for 2 clk -> active=0, every X=400, every Y=0, no pulses.
//  2 scene=1, SPAWN_PERIOD=4, 4 clk_en -> slot0 active, Y0=0, 72<=X0<200; next clk_en -> Y0=1.
//  3 Slot0 falls to Y=238 -> avoided[0]=1 for exactly 1 clk, X0=400, active[0]=0.
//  4 colision[0] and clk_en in same clk at Y0=50 -> killed[0]=1, Y0=0, active=0;
//    colision[1] with slot1 idle -> no pulse.
//  5 All 4 slots active at spawn time -> no change, spawn_cnt wraps; free slot2 -> next spawn uses slot2.
//  6 scene 1->0 mid-fall -> all slots IDLE next clk. With ENNEMY_DIFFICULTY_EN: 8 avoided -> step=2;
//    scene change -> step=1.

Source files
------------

// File: rtl/ennemy_wave_if.sv
// Playfield enemy bus: tick/scene/collision in, per-slot position and event pulses out.
// Latency: n/a (wiring only).
// Backpressure: none; pulses are single-cycle and must be consumed when seen.
// Signals:
//   clk_en    movement tick, one clk wide
//   scene     current game scene
//   colision  per-slot hit from the collision checker
//   X, Y      packed 9-bit coordinates, slot i at [9i+8:9i]
//   active    slot alive and drawn
//   avoided   1-clk pulse, slot reached the bottom limit
//   killed    1-clk pulse, slot hit while active
interface ennemy_wave_if #(
    parameter int N_ENEMY = 4
);
    logic                   clk_en;
    logic [1:0]             scene;
    logic [N_ENEMY-1:0]     colision;
    logic [9*N_ENEMY-1:0]   X;
    logic [9*N_ENEMY-1:0]   Y;
    logic [N_ENEMY-1:0]     active;
    logic [N_ENEMY-1:0]     avoided;
    logic [N_ENEMY-1:0]     killed;

    // Game side: drives tick, scene and hits; consumes positions and pulses.
    modport master (
        output clk_en, scene, colision,
        input  X, Y, active, avoided, killed
    );

    // Enemy generator side.
    modport slave (
        input  clk_en, scene, colision,
        output X, Y, active, avoided, killed
    );
endinterface

// File: rtl/ennemy_wave.sv
// Multi-slot falling-enemy generator: LFSR X spawn, timed spawning, kill/avoid detection.
// Latency: all outputs registered, every effect visible one clk after its cause.
// Backpressure: none; a spawn attempt with no free slot is dropped.
// Ports: clk, rst (sync, active-high), bus (ennemy_wave_if.slave: clk_en, scene,
//   colision in; X, Y, active, avoided, killed out).
// Option: define ENNEMY_DIFFICULTY_EN to raise the fall step with the avoided count.
module ennemy_wave #(
    parameter int         N_ENEMY      = 4,
    parameter int         X_MIN        = 72,
    parameter int         X_RANGE      = 128,
    parameter int         Y_MAX        = 238,
    parameter int         OFFSCREEN_X  = 400,
    parameter int         SPAWN_PERIOD = 60,
    parameter logic [1:0] PLAY_SCENE   = 2'd1
) (
    input  logic          clk,
    input  logic          rst,
    ennemy_wave_if.slave  bus
);
    localparam int             CW       = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(SPAWN_PERIOD - 1);
    localparam logic [8:0]     X_OFF    = 9'(OFFSCREEN_X);
    localparam logic [8:0]     Y_LIM    = 9'(Y_MAX);

    typedef enum logic {IDLE = 1'b0, FALL = 1'b1} slot_state_t;

    slot_state_t        state_q [N_ENEMY];
    slot_state_t        state_d [N_ENEMY];
    logic [8:0]         x_q [N_ENEMY];
    logic [8:0]         x_d [N_ENEMY];
    logic [8:0]         y_q [N_ENEMY];
    logic [8:0]         y_d [N_ENEMY];
    logic [N_ENEMY-1:0] avoided_q, avoided_d;
    logic [N_ENEMY-1:0] killed_q, killed_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [7:0]         lfsr_q, lfsr_d;
    logic [8:0]         step;
    logic [8:0]         spawn_x;
    logic [N_ENEMY-1:0] spawn_sel;
    logic               spawn_found;
    logic               in_play;
    logic               spawn_tick;

    assign in_play    = (bus.scene == PLAY_SCENE);
    assign spawn_tick = in_play && bus.clk_en && (cnt_q == CNT_LAST);
    assign spawn_x    = 9'(X_MIN) + 9'(32'(lfsr_q) % X_RANGE);

    // Lowest-index free slot, judged on the registered state so a slot
    // released in this clk only becomes eligible on the next one.
    always_comb begin
        spawn_sel   = '0;
        spawn_found = 1'b0;
        for (int i = 0; i < N_ENEMY; i++) begin
            if (!spawn_found && state_q[i] == IDLE) begin
                spawn_sel[i] = 1'b1;
                spawn_found  = 1'b1;
            end
        end
    end

    always_comb begin
        // Fibonacci LFSR, taps 8,6,5,4; runs every clk regardless of scene.
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        cnt_d = cnt_q;
        if (!in_play) begin
            cnt_d = '0;
        end else if (bus.clk_en) begin
            cnt_d = spawn_tick ? '0 : cnt_q + 1'b1;
        end

        for (int i = 0; i < N_ENEMY; i++) begin
            state_d[i]   = state_q[i];
            x_d[i]       = x_q[i];
            y_d[i]       = y_q[i];
            avoided_d[i] = 1'b0;
            killed_d[i]  = 1'b0;
            if (!in_play) begin
                state_d[i] = IDLE;
                x_d[i]     = X_OFF;
                y_d[i]     = '0;
            end else begin
                case (state_q[i])
                    FALL: begin
                        // Bottom check outranks a hit, a hit outranks a move.
                        if (y_q[i] >= Y_LIM) begin
                            state_d[i]   = IDLE;
                            x_d[i]       = X_OFF;
                            y_d[i]       = '0;
                            avoided_d[i] = 1'b1;
                        end else if (bus.colision[i]) begin
                            state_d[i]  = IDLE;
                            x_d[i]      = X_OFF;
                            y_d[i]      = '0;
                            killed_d[i] = 1'b1;
                        end else if (bus.clk_en) begin
                            y_d[i] = y_q[i] + step;
                        end
                    end
                    default: begin
                        if (spawn_tick && spawn_sel[i]) begin
                            state_d[i] = FALL;
                            x_d[i]     = spawn_x;
                            y_d[i]     = '0;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ENEMY; i++) begin
                state_q[i] <= IDLE;
                x_q[i]     <= X_OFF;
                y_q[i]     <= '0;
            end
            avoided_q <= '0;
            killed_q  <= '0;
            cnt_q     <= '0;
            lfsr_q    <= 8'hA5;
        end else begin
            for (int i = 0; i < N_ENEMY; i++) begin
                state_q[i] <= state_d[i];
                x_q[i]     <= x_d[i];
                y_q[i]     <= y_d[i];
            end
            avoided_q <= avoided_d;
            killed_q  <= killed_d;
            cnt_q     <= cnt_d;
            lfsr_q    <= lfsr_d;
        end
    end

`ifdef ENNEMY_DIFFICULTY_EN
    // Avoided counter saturates at 31 so the step stays pinned at 4
    // instead of collapsing back to 1 on wrap.
    logic [4:0] av_cnt_q, av_cnt_d;
    logic [5:0] av_sum;

    always_comb begin
        av_sum = {1'b0, av_cnt_q};
        for (int i = 0; i < N_ENEMY; i++) begin
            av_sum = av_sum + 6'(avoided_d[i]);
        end
        av_cnt_d = (av_sum > 6'd31) ? 5'd31 : av_sum[4:0];
        if (!in_play) begin
            av_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            av_cnt_q <= '0;
        end else begin
            av_cnt_q <= av_cnt_d;
        end
    end

    // One extra pixel per tick for each group of 8 avoided, 1..4.
    assign step = 9'd1 + 9'(av_cnt_q[4:3]);
`else
    assign step = 9'd1;
`endif

    for (genvar g = 0; g < N_ENEMY; g++) begin : g_out
        assign bus.X[9*g +: 9] = x_q[g];
        assign bus.Y[9*g +: 9] = y_q[g];
        assign bus.active[g]   = (state_q[g] == FALL);
    end
    assign bus.avoided = avoided_q;
    assign bus.killed  = killed_q;

endmodule

// File: tb/tb_ennemy_wave.sv
module tb_ennemy_wave;
    localparam int N  = 4;
    localparam int SP = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ennemy_wave_if #(.N_ENEMY(N)) bus ();

    ennemy_wave #(.N_ENEMY(N), .SPAWN_PERIOD(SP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vec  = 0;
    int errs = 0;

    task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_act [N];
    int m_x   [N];
    int m_y   [N];
    int m_av  [N];
    int m_kl  [N];
    int m_cnt, m_lfsr, m_avcnt;
    bit chk_on = 1'b0;

    always @(posedge clk) begin : model
        int target, step, npop, fb, grp;
        bit spawn_now;
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                m_act[i] = 0; m_x[i] = 400; m_y[i] = 0; m_av[i] = 0; m_kl[i] = 0;
            end
            m_cnt = 0; m_lfsr = 'hA5; m_avcnt = 0;
            chk_on = 1'b1;
        end else begin
            step = 1;
`ifdef ENNEMY_DIFFICULTY_EN
            grp  = m_avcnt / 8;
            step = 1 + ((grp > 3) ? 3 : grp);
`endif
            for (int i = 0; i < N; i++) begin
                m_av[i] = 0; m_kl[i] = 0;
            end
            if (bus.scene != 2'd1) begin
                for (int i = 0; i < N; i++) begin
                    m_act[i] = 0; m_x[i] = 400; m_y[i] = 0;
                end
                m_cnt = 0; m_avcnt = 0;
            end else begin
                spawn_now = 1'b0;
                if (bus.clk_en) begin
                    if (m_cnt == SP - 1) begin
                        m_cnt = 0; spawn_now = 1'b1;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
                target = -1;
                for (int i = 0; i < N; i++)
                    if (m_act[i] == 0 && target < 0) target = i;
                for (int i = 0; i < N; i++) begin
                    if (m_act[i] != 0) begin
                        if (m_y[i] >= 238) begin
                            m_act[i] = 0; m_x[i] = 400; m_y[i] = 0; m_av[i] = 1;
                        end else if (bus.colision[i]) begin
                            m_act[i] = 0; m_x[i] = 400; m_y[i] = 0; m_kl[i] = 1;
                        end else if (bus.clk_en) begin
                            m_y[i] = m_y[i] + step;
                        end
                    end else if (spawn_now && i == target) begin
                        m_act[i] = 1; m_y[i] = 0; m_x[i] = 72 + (m_lfsr % 128);
                    end
                end
                npop = 0;
                for (int i = 0; i < N; i++) npop += m_av[i];
                m_avcnt = (m_avcnt + npop > 31) ? 31 : m_avcnt + npop;
            end
            fb     = ((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1;
            m_lfsr = ((m_lfsr << 1) | fb) & 'hFF;
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [35:0] ex_x, ex_y;
    logic [3:0]  ex_a, ex_av, ex_kl;

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < N; i++) begin
                ex_x[9*i +: 9] = 9'(m_x[i]);
                ex_y[9*i +: 9] = 9'(m_y[i]);
                ex_a[i]  = (m_act[i] != 0);
                ex_av[i] = (m_av[i] != 0);
                ex_kl[i] = (m_kl[i] != 0);
            end
            chk("model_X", bus.X, ex_x);
            chk("model_Y", bus.Y, ex_y);
            chk("model_active", 36'(bus.active), 36'(ex_a));
            chk("model_avoided", 36'(bus.avoided), 36'(ex_av));
            chk("model_killed", 36'(bus.killed), 36'(ex_kl));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input bit ce, input logic [3:0] col);
        bus.clk_en   = ce;
        bus.colision = col;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 4'h0);
        tick(1'b0, 4'h0);
        rst = 1'b0;
    endtask

    logic [3:0] col;
    int n;

    initial begin
        rst          = 1'b1;
        bus.scene    = 2'd1;
        bus.clk_en   = 1'b0;
        bus.colision = '0;

        // Reset state
        do_reset();
        chk("rst_active", 36'(bus.active), 36'h0);
        chk("rst_X", bus.X, {4{9'd400}});
        chk("rst_Y", bus.Y, 36'h0);
        chk("rst_pulses", 36'({bus.avoided, bus.killed}), 36'h0);

        // First spawn after 4 ticks; LFSR A5->4A->95->2A gives X = 72+42
        for (int i = 0; i < 4; i++) tick(1'b1, 4'h0);
        chk("spawn_active", 36'(bus.active), 36'h1);
        chk("spawn_Y0", 36'(bus.Y[8:0]), 36'd0);
        chk("spawn_X0", 36'(bus.X[8:0]), 36'd114);
        chk("spawn_X0_range", 36'(bus.X[8:0] >= 9'd72 && bus.X[8:0] < 9'd200), 36'd1);
        tick(1'b1, 4'h0);
        chk("move_Y0", 36'(bus.Y[8:0]), 36'd1);

        // Fall to the bottom -> single avoided pulse
        n = 0;
        while (bus.Y[8:0] != 9'd238 && n < 400) begin
            tick(1'b1, 4'h0);
            n++;
        end
        chk("reach_238_in_budget", 36'(n < 400), 36'd1);
        tick(1'b0, 4'h0);
        chk("avoid_pulse", 36'(bus.avoided), 36'h1);
        chk("avoid_X0", 36'(bus.X[8:0]), 36'd400);
        chk("avoid_active0", 36'(bus.active[0]), 36'd0);
        tick(1'b0, 4'h0);
        chk("avoid_pulse_1clk", 36'(bus.avoided[0]), 36'd0);

        // Collision on idle slots, then collision + move at Y0=50
        do_reset();
        tick(1'b0, 4'hF);
        tick(1'b0, 4'hF);
        chk("idle_col_killed", 36'(bus.killed), 36'h0);
        chk("idle_col_active", 36'(bus.active), 36'h0);
        for (int i = 0; i < 4 + 50; i++) tick(1'b1, 4'h0);
        chk("pre_kill_Y0", 36'(bus.Y[8:0]), 36'd50);
        tick(1'b1, 4'b0001);
        chk("kill_pulse", 36'(bus.killed), 36'h1);
        chk("kill_Y0", 36'(bus.Y[8:0]), 36'd0);
        chk("kill_X0", 36'(bus.X[8:0]), 36'd400);
        chk("kill_active0", 36'(bus.active[0]), 36'd0);

        // All slots busy -> dropped spawn; free slot2 -> it is reused
        do_reset();
        for (int i = 0; i < 20; i++) tick(1'b1, 4'h0);
        chk("full_active", 36'(bus.active), 36'hF);
        chk("full_Y0", 36'(bus.Y[8:0]), 36'd16);
        chk("full_Y3", 36'(bus.Y[35:27]), 36'd4);
        tick(1'b0, 4'b0100);
        chk("free2_killed", 36'(bus.killed), 36'h4);
        chk("free2_active", 36'(bus.active), 36'hB);
        for (int i = 0; i < 3; i++) tick(1'b1, 4'h0);
        chk("wait_active", 36'(bus.active), 36'hB);
        tick(1'b1, 4'h0);
        chk("reuse_active", 36'(bus.active), 36'hF);
        chk("reuse_Y2", 36'(bus.Y[26:18]), 36'd0);
        chk("reuse_X2_range", 36'(bus.X[26:18] >= 9'd72 && bus.X[26:18] < 9'd200), 36'd1);

        // Leaving play mid-fall clears every slot
        bus.scene = 2'd0;
        tick(1'b1, 4'h0);
        chk("scene_active", 36'(bus.active), 36'h0);
        chk("scene_X", bus.X, {4{9'd400}});
        chk("scene_Y", bus.Y, 36'h0);
        chk("scene_pulses", 36'({bus.avoided, bus.killed}), 36'h0);
        bus.scene = 2'd1;

        // Randomised run against the model
        for (int c = 0; c < 6000; c++) begin
            rst = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 399) == 0) bus.scene = 2'($urandom_range(0, 3));
            else if (bus.scene != 2'd1 && $urandom_range(0, 19) == 0) bus.scene = 2'd1;
            for (int i = 0; i < N; i++) col[i] = ($urandom_range(0, 399) == 0);
            tick(1'($urandom_range(0, 1)), col);
        end
        rst = 1'b0;
        tick(1'b0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
